// File: rtl/kcpsmx_io_pkg.sv
// Shared register map, bit positions and interrupt FSM state type for the
// kcpsmx port-mapped I/O peripheral.
package kcpsmx_io_pkg;

  localparam logic [2:0] STATUS_OFS   = 3'd0;
  localparam logic [2:0] RX_DATA_OFS  = 3'd1;
  localparam logic [2:0] TX_DATA_OFS  = 3'd2;
  localparam logic [2:0] INT_MASK_OFS = 3'd3;
  localparam logic [2:0] CTRL_OFS     = 3'd4;

  localparam int unsigned ST_RX_NEMPTY = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_TX_FULL   = 3;
  localparam int unsigned ST_TX_EMPTY  = 4;
  localparam int unsigned ST_TX_OVF    = 5;

  localparam int unsigned CTRL_CLR_OVF  = 0;
  localparam int unsigned CTRL_FLUSH_RX = 1;
  localparam int unsigned CTRL_FLUSH_TX = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } int_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with synchronous flush. A push is ignored when full unless
// a pop happens in the same cycle; a pop is ignored when empty.
module io_sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; flush overrides any push/pop in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kcpsmx_io_port.sv
// kcpsmx port-mapped peripheral: RX/TX byte FIFOs behind an 8-entry register
// window, with a maskable interrupt request held until acknowledged.
module kcpsmx_io_port
  import kcpsmx_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        port_id,
  input  logic              read_strobe,
  input  logic              write_strobe,
  input  logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] in_port,
  output logic              interrupt,
  input  logic              interrupt_ack,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              hit;
  logic [2:0]        ofs;
  logic              rx_pop, rx_push, rx_flush, rx_full, rx_empty;
  logic              tx_pop, tx_push, tx_flush, tx_full, tx_empty;
  logic [AW:0]       rx_count, tx_count;
  logic [DATA_W-1:0] rx_head, tx_head;
  logic              ctrl_wr, mask_wr, ovf_set;
  logic              rx_nempty_st, tx_empty_st, int_cond;
  logic [1:0]        int_mask;
  logic              tx_ovf;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] status;
  int_state_t        int_state;

  assign hit      = (port_id[7:3] == BASE_ADDR[7:3]);
  assign ofs      = port_id[2:0];
  assign rx_pop   = read_strobe & hit & (ofs == RX_DATA_OFS);
  assign tx_push  = write_strobe & hit & (ofs == TX_DATA_OFS);
  assign ctrl_wr  = write_strobe & hit & (ofs == CTRL_OFS);
  assign mask_wr  = write_strobe & hit & (ofs == INT_MASK_OFS);
  assign rx_flush = ctrl_wr & out_port[CTRL_FLUSH_RX];
  assign tx_flush = ctrl_wr & out_port[CTRL_FLUSH_TX];

  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid & rx_ready;
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_data  = tx_empty ? '0 : tx_head;

  // A concurrent sink pop makes room, so only an unrelieved full drops the byte.
  assign ovf_set  = tx_push & tx_full & ~tx_pop & ~tx_flush;

  assign rx_nempty_st = (rx_count != '0);
  assign tx_empty_st  = (tx_count == '0);
  assign int_cond     = (rx_nempty_st & int_mask[0]) | (tx_empty_st & int_mask[1]);

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_push),
    .pop     (rx_pop),
    .flush   (rx_flush),
    .wr_data (rx_data),
    .head    (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .flush   (tx_flush),
    .wr_data (out_port),
    .head    (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .count   (tx_count)
  );

  // Assemble STATUS and select read data by register offset.
  always_comb begin
    status               = '0;
    status[ST_RX_NEMPTY] = rx_nempty_st;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty_st;
    status[ST_TX_OVF]    = tx_ovf;
    rd_mux = '0;
    if (hit) begin
      case (ofs)
        STATUS_OFS:   rd_mux = status;
        RX_DATA_OFS:  rd_mux = rx_empty ? '0 : rx_head;
        INT_MASK_OFS: rd_mux[1:0] = int_mask;
        default:      rd_mux = '0;
      endcase
    end
  end

  // Registered read port; a popping read captures the head before it advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_port <= '0;
    else          in_port <= rd_mux;
  end

  // Interrupt mask and sticky TX overflow flag (a new overflow beats a clear).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_mask <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (mask_wr) int_mask <= out_port[1:0];
      if (ctrl_wr && out_port[CTRL_CLR_OVF]) tx_ovf <= 1'b0;
      if (ovf_set) tx_ovf <= 1'b1;
    end
  end

  // Interrupt handshake: request, hold until ack, one quiet cycle, re-evaluate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_state <= IDLE;
      interrupt <= 1'b0;
    end else begin
      case (int_state)
        IDLE: begin
          if (int_cond) begin
            int_state <= REQ;
            interrupt <= 1'b1;
          end
        end
        REQ: begin
          if (interrupt_ack) begin
            int_state <= HOLDOFF;
            interrupt <= 1'b0;
          end
        end
        HOLDOFF: begin
          int_state <= IDLE;
          interrupt <= 1'b0;
        end
        default: begin
          int_state <= IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule
